conv1d_sequencer: RTL and testbench

CONV1D_SEQUENCER -- requirements
Module: conv1d_sequencer

---
 rtl/conv1d_sequencer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_conv1d_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_sequencer.sv
// ---------------------------------------------------------------------------
// conv1d_sequencer
//
// Walks a 1-D convolution engine through one job. It configures the engine,
// streams input columns into the engine's ring buffer, and once a full kernel
// window is resident it starts the engine, polls until done, reads the result
// and presents it on a valid/ready stream. While idle, the engine port is
// handed to the host.
//
// Ports
//   clk, reset                 sole clock; synchronous active-high reset
//   cfg_valid/cfg_ready        job descriptor handshake (accepted in IDLE)
//   cfg_depth                  input channels per column, legal 1..MAX_DEPTH
//   cfg_input_offset           forwarded to the engine
//   cfg_num_steps              number of input columns in the job
//   in_valid/in_ready/in_data  byte stream, channel-major per column
//   out_valid/out_ready/out_data  one 32-bit result per full window
//   host_en/host_cmd/host_inp0/host_inp1  host access to the engine in IDLE
//   host_ret                   engine response passthrough
//   cfu_en/cfu_cmd/cfu_inp0/cfu_inp1      engine command port
//   cfu_ret                    engine response, one cycle after the command
//   busy                       high in every state except IDLE
//   err                        sticky: bad descriptor or poll timeout
// ---------------------------------------------------------------------------
module conv1d_sequencer #(
  parameter int KERNEL_LENGTH = 8,
  parameter int MAX_DEPTH     = 128,
  parameter int POLL_TIMEOUT  = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [7:0]  cfg_depth,
  input  logic [31:0] cfg_input_offset,
  input  logic [15:0] cfg_num_steps,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  input  logic        host_en,
  input  logic [6:0]  host_cmd,
  input  logic [31:0] host_inp0,
  input  logic [31:0] host_inp1,
  output logic [31:0] host_ret,
  output logic        cfu_en,
  output logic [6:0]  cfu_cmd,
  output logic [31:0] cfu_inp0,
  output logic [31:0] cfu_inp1,
  input  logic [31:0] cfu_ret,
  output logic        busy,
  output logic        err
);

  localparam int PTR_W  = (KERNEL_LENGTH > 1) ? $clog2(KERNEL_LENGTH) : 1;
  localparam int PCNT_W = $clog2(POLL_TIMEOUT + 1);

  // Columns 0..KERNEL_LENGTH-2 only fill the ring; no window is complete yet.
  localparam logic [15:0]       WARMUP_STEPS = 16'(KERNEL_LENGTH - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST     = PTR_W'(KERNEL_LENGTH - 1);
  localparam logic [PCNT_W-1:0] POLL_LIMIT   = PCNT_W'(POLL_TIMEOUT);

  localparam logic [6:0] CMD_WRITE = 7'd1;
  localparam logic [6:0] CMD_OFS   = 7'd3;
  localparam logic [6:0] CMD_DEPTH = 7'd5;
  localparam logic [6:0] CMD_START = 7'd6;
  localparam logic [6:0] CMD_READ  = 7'd7;
  localparam logic [6:0] CMD_SETX  = 7'd8;
  localparam logic [6:0] CMD_POLL  = 7'd9;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_OFS, S_CFG_DEP, S_FILL, S_SETX,
    S_START, S_POLL, S_READ, S_CAPT, S_OUT
  } state_e;

  state_e             state_q,     state_d;
  logic [7:0]         depth_q,     depth_d;
  logic [31:0]        offset_q,    offset_d;
  logic [15:0]        num_steps_q, num_steps_d;
  logic [PTR_W-1:0]   ptr_q,       ptr_d;
  logic [15:0]        step_q,      step_d;
  logic [7:0]         col_idx_q,   col_idx_d;
  logic [PCNT_W-1:0]  poll_cnt_q,  poll_cnt_d;
  logic [31:0]        out_data_q,  out_data_d;
  logic               err_q,       err_d;

  logic [PTR_W-1:0]   ptr_next;
  logic [31:0]        fill_addr;
  logic               depth_bad;

  assign ptr_next  = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
  // Slot ptr holds one column of depth bytes; channel col_idx within it.
  assign fill_addr = 32'(ptr_q) * 32'(depth_q) + 32'(col_idx_q);
  assign depth_bad = (cfg_depth == 8'd0) || ({1'b0, cfg_depth} > 9'(MAX_DEPTH));

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    offset_d    = offset_q;
    num_steps_d = num_steps_q;
    ptr_d       = ptr_q;
    step_d      = step_q;
    col_idx_d   = col_idx_q;
    poll_cnt_d  = poll_cnt_q;
    out_data_d  = out_data_q;
    err_d       = err_q;

    cfg_ready   = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    cfu_en      = 1'b0;
    cfu_cmd     = '0;
    cfu_inp0    = '0;
    cfu_inp1    = '0;

    unique case (state_q)
      S_IDLE: begin
        cfg_ready = 1'b1;
        // Host owns the engine port while no job is running.
        cfu_en    = host_en;
        cfu_cmd   = host_en ? host_cmd : '0;
        cfu_inp0  = host_inp0;
        cfu_inp1  = host_inp1;
        if (cfg_valid) begin
          depth_d     = cfg_depth;
          offset_d    = cfg_input_offset;
          num_steps_d = cfg_num_steps;
          ptr_d       = '0;
          step_d      = '0;
          col_idx_d   = '0;
          if (depth_bad) begin
            err_d = 1'b1;
          end else begin
            err_d = 1'b0;
            if (cfg_num_steps != 16'd0) state_d = S_CFG_OFS;
          end
        end
      end

      S_CFG_OFS: begin
        cfu_en   = 1'b1;
        cfu_cmd  = CMD_OFS;
        cfu_inp1 = offset_q;
        state_d  = S_CFG_DEP;
      end

      S_CFG_DEP: begin
        cfu_en   = 1'b1;
        cfu_cmd  = CMD_DEPTH;
        cfu_inp1 = {24'b0, depth_q};
        state_d  = S_FILL;
      end

      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cfu_en   = 1'b1;
          cfu_cmd  = CMD_WRITE;
          cfu_inp0 = fill_addr;
          cfu_inp1 = {24'b0, in_data};
          if (col_idx_q == depth_q - 8'd1) begin
            col_idx_d = '0;
            ptr_d     = ptr_next;
            step_d    = step_q + 16'd1;
            if (step_q < WARMUP_STEPS) begin
              if (step_q + 16'd1 == num_steps_q) state_d = S_IDLE;
            end else begin
              state_d = S_SETX;
            end
          end else begin
            col_idx_d = col_idx_q + 8'd1;
          end
        end
      end

      S_SETX: begin
        // ptr has already advanced past the newest column: it is the oldest.
        cfu_en   = 1'b1;
        cfu_cmd  = CMD_SETX;
        cfu_inp1 = 32'(ptr_q);
        state_d  = S_START;
      end

      S_START: begin
        cfu_en     = 1'b1;
        cfu_cmd    = CMD_START;
        poll_cnt_d = '0;
        state_d    = S_POLL;
      end

      S_POLL: begin
        if (poll_cnt_q == POLL_LIMIT) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cfu_en     = 1'b1;
          cfu_cmd    = CMD_POLL;
          poll_cnt_d = poll_cnt_q + PCNT_W'(1);
          // The first POLL cycle sees the response to START, not to a poll.
          if ((poll_cnt_q != '0) && cfu_ret[0]) state_d = S_READ;
        end
      end

      S_READ: begin
        cfu_en  = 1'b1;
        cfu_cmd = CMD_READ;
        state_d = S_CAPT;
      end

      S_CAPT: begin
        out_data_d = cfu_ret;
        state_d    = S_OUT;
      end

      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = (step_q == num_steps_q) ? S_IDLE : S_FILL;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values computed before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      depth_q     <= '0;
      offset_q    <= '0;
      num_steps_q <= '0;
      ptr_q       <= '0;
      step_q      <= '0;
      col_idx_q   <= '0;
      poll_cnt_q  <= '0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      offset_q    <= offset_d;
      num_steps_q <= num_steps_d;
      ptr_q       <= ptr_d;
      step_q      <= step_d;
      col_idx_q   <= col_idx_d;
      poll_cnt_q  <= poll_cnt_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;
  assign out_data = out_data_q;
  assign host_ret = cfu_ret;

endmodule

// File: tb/tb_conv1d_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv1d_sequencer
//
// Drives random jobs into conv1d_sequencer against a behavioural engine.
// The expected command stream and results come from a column-level reference:
// column j lives in ring slot j mod 8, a window starting at column r produces
// one result computed directly from the streamed bytes. A negedge monitor
// pops the expectation queues whenever the DUT issues a command or a result.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_conv1d_sequencer;

  localparam int KL      = 8;
  localparam int TIMEOUT = 2048;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [7:0]  cfg_depth = '0;
  logic [31:0] cfg_input_offset = '0;
  logic [15:0] cfg_num_steps = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        host_en = 1'b0;
  logic [6:0]  host_cmd = '0;
  logic [31:0] host_inp0 = '0;
  logic [31:0] host_inp1 = '0;
  logic [31:0] host_ret;
  logic        cfu_en;
  logic [6:0]  cfu_cmd;
  logic [31:0] cfu_inp0;
  logic [31:0] cfu_inp1;
  logic [31:0] cfu_ret = '0;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  conv1d_sequencer #(
    .KERNEL_LENGTH(KL), .MAX_DEPTH(128), .POLL_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_depth(cfg_depth),
    .cfg_input_offset(cfg_input_offset), .cfg_num_steps(cfg_num_steps),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .host_en(host_en), .host_cmd(host_cmd), .host_inp0(host_inp0),
    .host_inp1(host_inp1), .host_ret(host_ret),
    .cfu_en(cfu_en), .cfu_cmd(cfu_cmd), .cfu_inp0(cfu_inp0),
    .cfu_inp1(cfu_inp1), .cfu_ret(cfu_ret),
    .busy(busy), .err(err)
  );

  typedef struct packed {
    logic [6:0]  cmd;
    logic [31:0] inp0;
    logic [31:0] inp1;
  } cmd_t;

  cmd_t        exp_cmd_q[$];
  logic [31:0] exp_out_q[$];
  logic [7:0]  stim [0:4095];

  int tests = 0;
  int fails = 0;
  int poll_total = 0;
  int out_total = 0;
  int cur_stall = 0;
  int max_stall = 0;
  logic        prev_stalled = 1'b0;
  logic [31:0] prev_out = '0;
  bit          hold_req = 1'b0;
  bit          eng_hang = 1'b0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b);
    cmd_t r;
    r.cmd = c; r.inp0 = a; r.inp1 = b;
    return r;
  endfunction

  // Reference result for the window of columns r..r+KL-1.
  function automatic logic [31:0] ref_window(input int r, input int depth, input logic [31:0] ofs);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < KL; k++)
      for (int c = 0; c < depth; c++)
        s += (32'(stim[(r + k) * depth + c]) + ofs) * 32'(k * 3 + c + 1);
    return s;
  endfunction

  // ---------------- behavioural engine ----------------
  logic [7:0]  eng_mem [0:1023];
  logic [31:0] eng_ofs = '0, eng_dep = '0, eng_x = '0, eng_res = '0;
  int          eng_cnt = 0;

  function automatic logic [31:0] engine_compute();
    logic [31:0] s;
    int x, d;
    s = '0;
    x = int'(eng_x[15:0]);
    d = (eng_dep > 32'd256) ? 256 : int'(eng_dep);
    for (int k = 0; k < KL; k++)
      for (int c = 0; c < d; c++)
        s += (32'(eng_mem[(((x + k) % KL) * d + c) % 1024]) + eng_ofs) * 32'(k * 3 + c + 1);
    return s;
  endfunction

  always @(posedge clk) begin
    logic [31:0] r;
    r = '0;
    if (cfu_en) begin
      case (cfu_cmd)
        7'd1: eng_mem[cfu_inp0[9:0]] = cfu_inp1[7:0];
        7'd3: eng_ofs = cfu_inp1;
        7'd5: eng_dep = cfu_inp1;
        7'd8: eng_x = cfu_inp1;
        7'd6: begin eng_res = engine_compute(); eng_cnt = $urandom_range(0, 12); end
        7'd9: begin
          r = 32'hA5A5_0000;
          if (!eng_hang && eng_cnt == 0) r[0] = 1'b1;
          else if (eng_cnt > 0) eng_cnt--;
        end
        7'd7: r = eng_res;
        default: ;
      endcase
    end
    cfu_ret <= r;
  end

  // ---------------- out_ready driver ----------------
  always begin
    @(posedge clk); #1;
    out_ready = hold_req ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    cmd_t e;
    if (!reset) begin
      if (busy && cfu_en) begin
        if (cfu_cmd == 7'd9) poll_total++;
        else if (exp_cmd_q.size() == 0) check("cmd_expected", 72'(cfu_cmd), 72'(0));
        else begin
          e = exp_cmd_q.pop_front();
          check("cfu_cmd", {1'b0, cfu_cmd, cfu_inp0, cfu_inp1}, {1'b0, e});
        end
      end
      if (busy && !cfu_en) check("cmd_zero_when_idle_port", 72'(cfu_cmd), 72'(0));
      if (out_valid) begin
        check("out_no_side_effects", 72'({in_ready, cfu_en}), 72'(0));
        if (prev_stalled) check("out_stable", 72'(out_data), 72'(prev_out));
        if (out_ready) begin
          out_total++;
          if (exp_out_q.size() == 0) check("out_expected", 72'(out_data), 72'(0));
          else check("out_data", 72'(out_data), 72'(exp_out_q.pop_front()));
        end
      end
      if (out_valid && !out_ready) cur_stall++;
      else cur_stall = 0;
      if (cur_stall > max_stall) max_stall = cur_stall;
      prev_stalled = out_valid && !out_ready;
      prev_out     = out_data;
    end
  end

  // ---------------- job tasks ----------------
  int poll_base, out_base;

  task automatic start_job(input int depth, input logic [31:0] ofs, input int steps, input bit hang);
    int total, idx, guard;
    bit acc;
    total = depth * steps;
    for (int i = 0; i < total; i++) stim[i] = 8'($urandom);
    poll_base = poll_total;
    out_base  = out_total;
    if (steps > 0) begin
      exp_cmd_q.push_back(mk(7'd3, 32'd0, ofs));
      exp_cmd_q.push_back(mk(7'd5, 32'd0, 32'(depth)));
    end
    for (int j = 0; j < steps; j++) begin
      for (int c = 0; c < depth; c++)
        exp_cmd_q.push_back(mk(7'd1, 32'((j % KL) * depth + c), {24'b0, stim[j * depth + c]}));
      if (j >= KL - 1) begin
        exp_cmd_q.push_back(mk(7'd8, 32'd0, 32'((j + 1) % KL)));
        exp_cmd_q.push_back(mk(7'd6, 32'd0, 32'd0));
        if (!hang) begin
          exp_cmd_q.push_back(mk(7'd7, 32'd0, 32'd0));
          exp_out_q.push_back(ref_window(j - KL + 1, depth, ofs));
        end
      end
    end
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_depth = 8'(depth); cfg_input_offset = ofs; cfg_num_steps = 16'(steps);
    guard = 0;
    @(negedge clk);
    while (!cfg_ready && guard < 100) begin @(negedge clk); guard++; end
    if (!cfg_ready) check("cfg_accept_timeout", 72'(cfg_ready), 72'(1));
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    idx = 0; guard = 0;
    while (idx < total && guard < 20000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = stim[idx];
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    if (idx < total) check("stream_timeout", 72'(idx), 72'(total));
  endtask

  task automatic finish_job(input int steps, input bit hang, input bit hold);
    int guard, exp_res;
    if (hold) begin
      guard = 0;
      @(negedge clk);
      while (!out_valid && guard < 500) begin @(negedge clk); guard++; end
      check("hold_reached_out", 72'(out_valid), 72'(1));
      repeat (50) @(negedge clk);
      hold_req = 1'b0;
    end
    guard = 0;
    @(negedge clk);
    while (busy && guard < 10000) begin @(negedge clk); guard++; end
    exp_res = (hang || steps < KL) ? 0 : steps - (KL - 1);
    check("job_done", 72'(busy), 72'(0));
    check("result_count", 72'(out_total - out_base), 72'(exp_res));
    check("err_after_job", 72'(err), 72'(hang));
    check("cmd_queue_drained", 72'(exp_cmd_q.size()), 72'(0));
    check("out_queue_drained", 72'(exp_out_q.size()), 72'(0));
    if (hang) check("poll_count", 72'(poll_total - poll_base), 72'(TIMEOUT));
  endtask

  task automatic run_job(input int depth, input logic [31:0] ofs, input int steps);
    start_job(depth, ofs, steps, 1'b0);
    finish_job(steps, 1'b0, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_state", 72'({busy, out_valid, err, cfu_en, cfu_cmd, cfg_ready}), 72'({10'b0, 1'b1}));
    check("reset_out_data", 72'(out_data), 72'(0));

    // Single window, depth 2, offset 128.
    run_job(2, 32'd128, 8);
    // Three windows, ring wraps for column 8.
    run_job(4, 32'h0000_0010, 10);

    // Output held off for 50 cycles.
    hold_req = 1'b1;
    start_job(3, 32'd7, 8, 1'b0);
    finish_job(8, 1'b0, 1'b1);
    check("stall_len_ok", 72'(max_stall >= 50), 72'(1));

    // Illegal depth 0, then depth 200, then a legal empty job.
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_depth = 8'd0; cfg_num_steps = 16'd8;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bad_depth_quiet", 72'({busy, cfu_en, err}), 72'(3'b001));
    end
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_depth = 8'd200;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    check("bad_depth_200", 72'({busy, err}), 72'(2'b01));
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_depth = 8'd5; cfg_num_steps = 16'd0;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    check("legal_clears_err", 72'({busy, err}), 72'(2'b00));

    // Random jobs, including warm-up-only and empty ones.
    for (int t = 0; t < 8; t++)
      run_job($urandom_range(1, 12), $urandom, $urandom_range(0, 13));
    run_job(128, 32'hFFFF_FF80, 9);

    // Engine never finishes: timeout.
    eng_hang = 1'b1;
    start_job(1, 32'd3, 8, 1'b1);
    finish_job(8, 1'b1, 1'b0);

    // Reset while polling, then host passthrough.
    start_job(2, 32'd1, 8, 1'b1);
    guard = 0;
    @(negedge clk);
    while ((poll_total - poll_base) < 10 && guard < 500) begin @(negedge clk); guard++; end
    check("reached_poll", 72'((poll_total - poll_base) >= 10), 72'(1));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_in_poll", 72'({busy, out_valid, err, cfu_en}), 72'(0));
    @(posedge clk); #1;
    reset = 1'b0; host_en = 1'b1; host_cmd = 7'd9; host_inp0 = '0; host_inp1 = '0;
    @(negedge clk);
    check("host_passthrough", 72'({cfu_en, cfu_cmd, busy}), 72'({1'b1, 7'd9, 1'b0}));
    check("host_ret_before", 72'(host_ret), 72'(0));
    @(posedge clk); #1;
    host_en = 1'b0;
    @(negedge clk);
    check("host_ret_after", 72'(host_ret), 72'(32'hA5A5_0000));
    check("abort_queue_empty", 72'(exp_cmd_q.size() + exp_out_q.size()), 72'(0));
    eng_hang = 1'b0;

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
